// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU engine producing {HI, LO}.
// Radix-2 shift-add multiply and restoring divide over 32 RUN cycles, then sign fix-up.
// Optional build macro MULT_DIV_FAST_MULT_EN: multiplies use a single-cycle product
// at acceptance and skip RUN. Divide timing is the same in both builds.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  func_code,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        div_by_zero
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 64;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

    state_t          state;
    logic            op_div;
    logic            neg_res;
    logic            neg_rem;
    logic [DW-1:0]   a_mag_q;
    logic [DW-1:0]   b_mag_q;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   acc;

    logic            valid_fc;
    logic            is_signed;
    logic            is_div;
    logic            a_neg;
    logic            b_neg;
    logic [DW-1:0]   a_mag;
    logic [DW-1:0]   b_mag;
    logic            accept;
    logic [RW-1:0]   mul_add;
    logic [DW:0]     div_shift;
    logic [DW+1:0]   div_diff;

    // Operand decode and magnitude extraction for the request at the input.
    assign valid_fc  = (func_code[5:2] == 4'b0110);
    assign is_signed = ~func_code[0];
    assign is_div    = func_code[1];
    assign a_neg     = is_signed & operand_a[DW-1];
    assign b_neg     = is_signed & operand_b[DW-1];
    assign a_mag     = a_neg ? (~operand_a + 32'd1) : operand_a;
    assign b_mag     = b_neg ? (~operand_b + 32'd1) : operand_b;

    // A new op is taken only once the previous done pulse has retired.
    assign accept    = (state == IDLE) && start && valid_fc && !done;

    // One multiply step: partial product for multiplier bit cnt.
    assign mul_add   = b_mag_q[cnt] ? (RW'(a_mag_q) << cnt) : '0;

    // One restoring-divide step: HI holds the remainder, LO the quotient/dividend.
    assign div_shift = {acc[RW-1:DW], acc[DW-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_mag_q};

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            op_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            cnt         <= '0;
            acc         <= '0;
        end else begin
            done <= 1'b0;
            busy <= accept || (state != IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_div  <= is_div;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        a_mag_q <= a_mag;
                        b_mag_q <= b_mag;
                        cnt     <= '0;
                        if (is_div && (operand_b == '0)) begin
                            result      <= {operand_a, 32'hFFFF_FFFF};
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else if (is_div) begin
                            acc   <= {32'd0, a_mag};
                            state <= RUN;
                        end else begin
`ifdef MULT_DIV_FAST_MULT_EN
                            acc   <= RW'(a_mag) * RW'(b_mag);
                            state <= SIGN;
`else
                            acc   <= '0;
                            state <= RUN;
`endif
                        end
                    end
                end
                RUN: begin
                    if (op_div) begin
                        if (!div_diff[DW+1]) begin
                            acc <= {div_diff[DW-1:0], acc[DW-2:0], 1'b1};
                        end else begin
                            acc <= {div_shift[DW-1:0], acc[DW-2:0], 1'b0};
                        end
                    end else begin
                        acc <= acc + mul_add;
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    if (op_div) begin
                        result[RW-1:DW] <= neg_rem ? (~acc[RW-1:DW] + 32'd1) : acc[RW-1:DW];
                        result[DW-1:0]  <= neg_res ? (~acc[DW-1:0] + 32'd1) : acc[DW-1:0];
                    end else begin
                        result <= neg_res ? (~acc + 64'd1) : acc;
                    end
                    div_by_zero <= 1'b0;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
